// File: rtl/lc3b_types.sv
// Shared LC-3b MEM-stage types: word, byte-enable mask and the state
// encoding of the indirect (LDI/STI) memory sequencer.
package lc3b_types;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [1:0]        lc3b_mem_wmask;

    // Full-word byte enable used for every indirect access.
    localparam lc3b_mem_wmask WMASK_WORD = 2'b11;

    // IDLE    : pass-through, or accept an LDI/STI
    // PTR     : read the pointer word
    // DATA_RD : LDI data read through the pointer
    // DATA_WR : STI data write through the pointer
    // DONE    : present LDI data, let the pipeline advance
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PTR     = 3'd1,
        DATA_RD = 3'd2,
        DATA_WR = 3'd3,
        DONE    = 3'd4
    } indirect_state_t;

endpackage

// File: rtl/indirect_mem_sequencer.sv
// MEM-stage data-cache port owner. Ordinary loads/stores pass straight
// through; LDI/STI become a pointer read followed by a data read or write,
// with sti_ldi_sig freezing the pipeline until the indirect access is done.
//
// Cache handshake: a request (dmem_read or dmem_write with address, data and
// byte enables) is held stable every cycle until the cycle in which
// dmem_resp is high; the request is dropped or retargeted on the following
// rising edge. dmem_resp is a one-cycle pulse and dmem_rdata is valid only
// alongside it. dmem_resp seen in IDLE or DONE carries no meaning here.
module indirect_mem_sequencer
    import lc3b_types::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ldi,
    input  logic               sti,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [WIDTH-1:0]   mem_address,
    input  logic [WIDTH-1:0]   mem_wdata,
    input  lc3b_mem_wmask      mem_byte_enable,
    output logic               dmem_read,
    output logic               dmem_write,
    output logic [WIDTH-1:0]   dmem_address,
    output logic [WIDTH-1:0]   dmem_wdata,
    output lc3b_mem_wmask      dmem_byte_enable,
    input  logic               dmem_resp,
    input  logic [WIDTH-1:0]   dmem_rdata,
    output logic [WIDTH-1:0]   mem_rdata,
    output logic               sti_ldi_sig,
    output indirect_state_t    dbg_state
);

    indirect_state_t  state;
    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] store_q;
    logic             is_sti_q;

    logic             indirect_req;

    // LDI wins when both decode bits are set, so only a pure STI writes.
    assign indirect_req = ldi | sti;
    assign dbg_state    = state;

    // Sequencer state and the pointer/data/store holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr_q    <= '0;
            data_q   <= '0;
            store_q  <= '0;
            is_sti_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (indirect_req) begin
                        store_q  <= mem_wdata;
                        is_sti_q <= sti & ~ldi;
                        state    <= PTR;
                    end
                end
                PTR: begin
                    if (dmem_resp) begin
                        ptr_q <= {dmem_rdata[WIDTH-1:1], 1'b0};
                        state <= is_sti_q ? DATA_WR : DATA_RD;
                    end
                end
                DATA_RD: begin
                    if (dmem_resp) begin
                        data_q <= dmem_rdata;
                        state  <= DONE;
                    end
                end
                DATA_WR: begin
                    if (dmem_resp) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Cache-port mux, read-data return and stall request for each state.
    always_comb begin
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = '0;
        mem_rdata        = dmem_rdata;
        sti_ldi_sig      = 1'b0;
        case (state)
            IDLE: begin
                // Address/data/enables pass through; only the strobes are
                // suppressed while an indirect access is being accepted.
                dmem_address     = mem_address;
                dmem_wdata       = mem_wdata;
                dmem_byte_enable = mem_byte_enable;
                if (indirect_req) begin
                    sti_ldi_sig = 1'b1;
                end else begin
                    dmem_read  = mem_read;
                    dmem_write = mem_write;
                end
            end
            PTR: begin
                dmem_read        = 1'b1;
                dmem_address     = {mem_address[WIDTH-1:1], 1'b0};
                dmem_byte_enable = WMASK_WORD;
                sti_ldi_sig      = 1'b1;
            end
            DATA_RD: begin
                dmem_read        = 1'b1;
                dmem_address     = ptr_q;
                dmem_byte_enable = WMASK_WORD;
                sti_ldi_sig      = 1'b1;
            end
            DATA_WR: begin
                dmem_write       = 1'b1;
                dmem_address     = ptr_q;
                dmem_wdata       = store_q;
                dmem_byte_enable = WMASK_WORD;
                sti_ldi_sig      = 1'b1;
            end
            DONE: begin
                mem_rdata = data_q;
            end
            default: begin
            end
        endcase
    end

endmodule
